// File: rtl/ball_vcounter_sync.sv
// ball_vcounter_sync
// Vertical position counter for one moving object in the Pong video path.
// It advances once per horizontal sync pulse during the active field. At
// terminal count it reloads from the motion value that was captured at the
// start of the previous vertical blank. It also produces the object's
// vertical video window. Everything runs on a single clock.
//
// Optional feature: define BALL_VCNT_STATUS_EN to add a sticky wrap_flag
// status bit, which is cleared by wrap_clr.
//
// Tick/blank events are derived from registered copies of the active-low
// sync inputs, so all decisions are made on the clk edge that samples the
// new input level.

module ball_vcounter_sync #(
    parameter int WIDTH  = 8,
    parameter int MOT_W  = 4,
    parameter int HEIGHT = 4
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             _hsync,
    input  logic             _vblank,
    input  logic [MOT_W-1:0] mot,
`ifdef BALL_VCNT_STATUS_EN
    input  logic             wrap_clr,
`endif
    output logic [WIDTH-1:0] vcount,
    output logic             vterm,
    output logic             vvid,
    output logic             _vvid
`ifdef BALL_VCNT_STATUS_EN
    ,
    output logic             wrap_flag
`endif
);

    // Terminal count value and first line of the object window.
    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] VVID_START = ALL_ONES - WIDTH'(HEIGHT - 1);

    logic             hs_q;
    logic             vb_q;
    logic [MOT_W-1:0] mot_q;
    logic             tick;
    logic             blank_start;
    logic             at_term;
    logic             reload;

    // hs_q resets high so a sync line that is already high at release is
    // not seen as a rising edge.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) hs_q <= 1'b1;
        else         hs_q <= _hsync;
    end

    // Registered vertical blank, used to find the start of blanking.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) vb_q <= 1'b1;
        else         vb_q <= _vblank;
    end

    // Event decode: end of sync pulse, start of blanking, terminal count.
    always_comb begin
        tick        = _hsync & ~hs_q;
        blank_start = ~_vblank & vb_q;
        at_term     = (vcount == ALL_ONES);
        reload      = tick & _vblank & at_term;
    end

    // Capture the motion value once per frame, at the start of blanking.
    // A reload on that same edge still uses the previous value.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset)          mot_q <= '0;
        else if (blank_start) mot_q <= mot;
    end

    // Line counter: the counter holds during blanking, reloads at terminal
    // count and otherwise increments once per tick.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            vcount <= '0;
        end else if (tick && _vblank) begin
            if (at_term) vcount <= WIDTH'(mot_q);
            else         vcount <= vcount + WIDTH'(1);
        end
    end

    // Window and terminal outputs, combinational from the count.
    always_comb begin
        vterm = at_term & _vblank;
        vvid  = (vcount >= VVID_START);
        _vvid = ~vvid;
    end

`ifdef BALL_VCNT_STATUS_EN
    // Sticky wrap status: a reload sets it; a clear loses to a
    // simultaneous set.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset)       wrap_flag <= 1'b0;
        else if (reload)   wrap_flag <= 1'b1;
        else if (wrap_clr) wrap_flag <= 1'b0;
    end
`endif

endmodule
